// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared types and constants for the Johnson-coded digit scanner
package grey_pkg;

    localparam int NUM_DIGITS = 12;
    localparam int DIGIT_W    = 5;
    localparam int IDX_W      = 4;
    localparam int SNAP_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FRAME = 3'd4
    } state_e;

    localparam logic [DIGIT_W-1:0] JC_0 = 5'b00000;
    localparam logic [DIGIT_W-1:0] JC_1 = 5'b00001;
    localparam logic [DIGIT_W-1:0] JC_2 = 5'b00011;
    localparam logic [DIGIT_W-1:0] JC_3 = 5'b00111;
    localparam logic [DIGIT_W-1:0] JC_4 = 5'b01111;
    localparam logic [DIGIT_W-1:0] JC_5 = 5'b11111;
    localparam logic [DIGIT_W-1:0] JC_6 = 5'b11110;
    localparam logic [DIGIT_W-1:0] JC_7 = 5'b11100;
    localparam logic [DIGIT_W-1:0] JC_8 = 5'b11000;
    localparam logic [DIGIT_W-1:0] JC_9 = 5'b10000;

    // Segment order {g,f,e,d,c,b,a}; the decimal point is added by the scanner.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Highest digit position holding a non-zero code; 0 when every digit is zero.
    function automatic logic [IDX_W-1:0] lead_index(input logic [SNAP_W-1:0] snap);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (snap[k*DIGIT_W +: DIGIT_W] != JC_0) begin
                idx = IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grey_seg7.sv
// rtl/grey_seg7.sv - Johnson digit to seven-segment decoder with validity flag
module grey_seg7
    import grey_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_code,
    output logic               o_valid,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_valid = 1'b1;
        o_seg   = SEG_DASH;
        case (i_code)
            JC_0:    o_seg = SEG_0;
            JC_1:    o_seg = SEG_1;
            JC_2:    o_seg = SEG_2;
            JC_3:    o_seg = SEG_3;
            JC_4:    o_seg = SEG_4;
            JC_5:    o_seg = SEG_5;
            JC_6:    o_seg = SEG_6;
            JC_7:    o_seg = SEG_7;
            JC_8:    o_seg = SEG_8;
            JC_9:    o_seg = SEG_9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/grey_scan.sv
// rtl/grey_scan.sv - multiplexed 12-digit Johnson counter display scanner
module grey_scan
    import grey_pkg::*;
#(
    parameter int DWELL = 1024,
    parameter int GAP   = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [SNAP_W-1:0] i_digits,
    output logic [7:0]        o_seg,
    output logic              o_frame,
    output logic              o_err
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);

    state_e              state_q, state_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;

    logic [DIGIT_W-1:0]  snap_digit [NUM_DIGITS];
    logic                dig_valid;
    logic [6:0]          dig_seg;

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            snap_digit[k] = snap_q[k*DIGIT_W +: DIGIT_W];
        end
    end

    grey_seg7 u_seg7 (
        .i_code  (snap_digit[idx_q]),
        .o_valid (dig_valid),
        .o_seg   (dig_seg)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        seg_d   = 8'h00;
        err_d   = err_q;

        if (state_q == ST_SHOW) begin
            seg_d = {(idx_q == '0), dig_seg};
            if (!dig_valid) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_LOAD;
                    snap_d  = i_digits;
                end
            end
            ST_LOAD: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHOW;
                    idx_d   = lead_index(snap_q);
                    cnt_d   = DWELL_LAST;
                end
            end
            ST_SHOW: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (idx_q != '0) begin
                    state_d = ST_SHOW;
                    idx_d   = idx_q - IDX_W'(1);
                    cnt_d   = DWELL_LAST;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (i_en) begin
                    state_d = ST_LOAD;
                    snap_d  = i_digits;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the pulse coincides exactly with the FRAME state cycle.
        frame_d = (state_d == ST_FRAME);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= 8'h00;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_frame = frame_q;
    assign o_err   = err_q;

endmodule

// File: doc/grey_scan.md
GREY_SCAN -- requirements
Module: grey_scan

Interface
REQ-001 Parameter DWELL, default 1024, SHALL set the cycles each digit is shown (legal range 1..65535).
REQ-002 Parameter GAP, default 128, SHALL set the blank cycles after each digit (legal range 1..65535).
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_en  input  1  SHALL be the scan enable.
REQ-006 i_digits  input  60  SHALL carry 12 counter digits, 5 bits each; digit k is at [5k+4:5k], ones = k0, hundred-billions = k11.
REQ-007 o_seg  output  8  SHALL drive the seven-segment display, bit order {dp,g,f,e,d,c,b,a}, active-high.
REQ-008 o_frame  output  1  SHALL pulse high for one cycle at the end of each complete frame.
REQ-009 o_err  output  1  SHALL be a sticky invalid-code flag.

Function
REQ-010 Each digit SHALL use Johnson code: 0=00000, 1=00001, 2=00011, 3=00111, 4=01111, 5=11111, 6=11110, 7=11100, 8=11000, 9=10000.
REQ-011 Any other 5-bit code SHALL be invalid: it displays dash 0x40 and sets o_err.
REQ-012 FSM states SHALL be IDLE, LOAD, SHOW, GAP and FRAME.
REQ-013 IDLE with i_en=1 SHALL go to LOAD; IDLE with i_en=0 SHALL stay in IDLE.
REQ-014 LOAD SHALL last one cycle:
- on the edge entering LOAD, i_digits is captured into a 60-bit snapshot;
- LOAD then computes the start index, the highest k whose snapshot digit is not code 0, or 0 if all digits are 0;
- LOAD then goes to SHOW.
REQ-015 SHOW SHALL last exactly DWELL cycles, then go to GAP.
REQ-016 GAP SHALL last exactly GAP cycles; it then goes to SHOW with index-1 if index>0, else to FRAME.
REQ-017 FRAME SHALL last one cycle with o_frame=1, then go to LOAD if i_en=1, else IDLE.
REQ-018 Digits above the start index SHALL be skipped (leading-zero blanking); zeros below the start index SHALL be shown.
REQ-019 o_seg SHALL be registered and lag the state by one cycle:
- a cycle in SHOW yields the decoded pattern of the snapshot digit at the current index one cycle later;
- all other states yield 0x00 one cycle later.
REQ-020 dp (o_seg[7]) SHALL be 1 only while digit index 0 is shown, marking frame end.
REQ-021 i_digits changes during a frame SHALL NOT affect that frame; only the snapshot is displayed.
REQ-022 Deasserting i_en in LOAD, SHOW or GAP SHALL abort: the next state is IDLE, o_seg goes to 0x00 one cycle later, and o_frame stays 0.
REQ-023 Dwell and gap counters SHALL be 16 bits, reload on state entry, and never wrap within a state.
REQ-024 Frame length SHALL be 2 + (start+1)×(DWELL+GAP) cycles, counted from LOAD entry to FRAME inclusive.
REQ-025 o_err SHALL set in the cycle after an invalid digit is shown; it clears only on reset.

Reset
REQ-026 i_rst=1 SHALL force state IDLE, index 0, counters 0, snapshot 0, o_seg=0x00, o_frame=0 and o_err=0 on the next edge, including mid-frame.
REQ-027 i_rst SHALL take priority over i_en.

Structure
REQ-028 Package grey_pkg SHALL hold:
- the state enum;
- the ten Johnson code constants;
- segment constants SEG_0..SEG_9 (0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F) and SEG_DASH=0x40;
- the digit count 12 and digit width 5.
REQ-029 One combinational sub-module, grey_seg7, SHALL map a 5-bit Johnson digit to {valid, seg[6:0]}; everything else lives in grey_scan.

Verification (bench uses DWELL=4, GAP=2)
REQ-030 Value 305: ones=11111, tens=00000, hund=00111, others 00000, i_en=1 -> o_seg shows 0x4F ×4, 0x00 ×2, 0x3F ×4, 0x00 ×2, 0xED ×4, 0x00 ×2; o_frame is high on cycle 20 after LOAD entry.
REQ-031 All digits 00000 -> a single 0xBF ×4 per frame; frame length 8 cycles.
REQ-032 Tens=01010, ones=00001 -> 0x40 shown for tens, then 0x86; o_err=1 and stays 1 across later valid frames.
REQ-033 Value 305 is loaded, then i_digits changes to all 9s during the 0x3F dwell -> 0xED still follows; the next frame shows twelve 0x6F digits, the last 0xEF.
REQ-034 i_en dropped mid-SHOW -> o_seg=0x00 within 2 cycles and no o_frame; i_en raised again -> a fresh LOAD.
REQ-035 i_rst pulsed mid-GAP with o_err=1 -> all outputs 0 the next cycle; the scan restarts from LOAD after release with i_en=1.
